// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, widths and the
// buffered command record.
package alu_pkg;

   localparam int OP_W   = 4;
   localparam int DATA_W = 8;

   localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
   localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
   localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
   localparam logic [OP_W-1:0] OP_AND  = 4'd4;
   localparam logic [OP_W-1:0] OP_OR   = 4'd5;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
   localparam logic [OP_W-1:0] OP_NOR  = 4'd7;
   localparam logic [OP_W-1:0] OP_NAND = 4'd8;
   localparam logic [OP_W-1:0] OP_XNOR = 4'd9;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command-in / result-out handshake bundle of the ALU command sequencer.
interface alu_cmd_sequencer_if;
   import alu_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_op;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic              out_carry;
   logic              out_zero;
   logic              out_err;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_carry, out_zero, out_err
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_carry, out_zero, out_err
   );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; the head entry is visible combinationally so the
// ALU can be fed directly from it.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push,
   input  logic           pop,
   input  cmd_t           wdata,
   output cmd_t           rdata,
   output logic           full,
   output logic           empty,
   output logic [PTR_W:0] count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   cmd_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap on natural overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives the combinational ALU from the FIFO head and
// registers its result plus status flags for a valid/ready consumer.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_cmd_sequencer_if.slave bus,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [OP_W-1:0]    alu_op,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic               alu_cout,
   output logic [15:0]        cmd_count
);

   cmd_t              in_cmd;
   cmd_t              head;
   logic              full;
   logic              empty;
   logic [PTR_W:0]    count;
   logic              has_cmd;
   logic              issue;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_result_q;
   logic              out_carry_q;
   logic              out_zero_q;
   logic              out_err_q;

   logic [DATA_W-1:0] nxt_result;
   logic              nxt_carry;
   logic              nxt_err;

   assign in_cmd  = {bus.in_op, bus.in_a, bus.in_b};
   assign has_cmd = (count != '0);
   assign issue   = has_cmd && (!out_valid_q || bus.out_ready);

   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.in_valid),
      .pop   (issue),
      .wdata (in_cmd),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Idle ALU inputs are a benign AND of zeros so it never sees X
   assign alu_a  = empty ? '0     : head.a;
   assign alu_b  = empty ? '0     : head.b;
   assign alu_op = empty ? OP_AND : head.op;

   always_comb begin
      nxt_result = alu_result;
      nxt_carry  = (head.op == OP_ADD) ? alu_cout : 1'b0;
      nxt_err    = 1'b0;
      if (head.op > OP_XNOR) begin
         nxt_result = 8'h00;
         nxt_carry  = 1'b0;
         nxt_err    = 1'b1;
      end else if (head.op == OP_DIV && head.b == '0) begin
         nxt_result = 8'hFF;
         nxt_carry  = 1'b0;
         nxt_err    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_carry_q  <= 1'b0;
         out_zero_q   <= 1'b0;
         out_err_q    <= 1'b0;
         cmd_count    <= '0;
      end else begin
         if (issue) begin
            out_valid_q  <= 1'b1;
            out_result_q <= nxt_result;
            out_carry_q  <= nxt_carry;
            out_zero_q   <= (nxt_result == '0);
            out_err_q    <= nxt_err;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (out_valid_q && bus.out_ready) cmd_count <= cmd_count + 16'd1;
      end
   end

   assign bus.in_ready   = !full;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_carry  = out_carry_q;
   assign bus.out_zero   = out_zero_q;
   assign bus.out_err    = out_err_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Operand/command front end for the 8-bit combinational ALU; sits directly upstream of it and also captures its output.
- Accepts {operation, A, B} commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle to the ALU, registers the ALU's result and Cout, and forms status flags.
- Presents the registered result downstream over a valid/ready handshake.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset, applied immediately on assertion; release is synchronised externally.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept; high when count < DEPTH.
- in_op  in  4  ALU operation code: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 NAND, 9 XNOR.
- in_a  in  8  operand A.
- in_b  in  8  operand B.
- alu_a  out  8  to ALU A; FIFO head A, or 0 when FIFO empty.
- alu_b  out  8  to ALU B; FIFO head B, or 0 when FIFO empty.
- alu_op  out  4  to ALU operation; FIFO head op, or 4'b0100 (AND) when FIFO empty, so the ALU never sees X.
- alu_result  in  8  from ALU result.
- alu_cout  in  1  from ALU Cout (carry of A+B).
- out_valid  out  1  registered result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  8  registered result.
- out_carry  out  1  alu_cout captured for ADD; 0 for all other ops.
- out_zero  out  1  out_result == 0.
- out_err  out  1  illegal op (>9) or DIV with B == 0.
- cmd_count  out  16  commands completed (output handshakes); wraps at 16'hFFFF -> 0.

Behaviour:
- Reset values: in_ready 1, out_valid 0, out_result 0, out_carry 0, out_zero 0, out_err 0, cmd_count 0. FIFO pointers and count are 0.
- Reset mid-operation discards all buffered commands and any pending output immediately.
- FIFO push: in_valid && in_ready.
- Output register free: !out_valid || out_ready.
- Issue: FIFO non-empty && output register free. On issue, the FIFO pops the head and the output register captures in the same edge.
- Capture rules:
  - Normal: out_result = alu_result; out_carry = (op == 0) ? alu_cout : 0.
  - Illegal op (>9): out_result = 8'h00, out_err = 1, carry 0.
  - DIV with B == 0: out_result = 8'hFF, out_err = 1, carry 0. The ALU value is not used.
  - out_zero is computed from the final captured out_result.
- Arithmetic is defined by the ALU and truncated to 8 bits: SUB wraps, MUL keeps the low 8 bits, DIV truncates the quotient.
- Latency: a command accepted at edge N (FIFO empty, output free) is issued and captured at edge N+1; out_valid is high after N+1.
- Throughput: one command per cycle while out_ready stays high.
- Backpressure: while out_valid && !out_ready, the output register holds stable and no issue occurs. The FIFO fills until in_ready drops at count == DEPTH.
- Simultaneous push and pop when full: not allowed, because in_ready is registered-count based and is low when full. Push when empty plus issue in the same cycle: no bypass; the command issues on the next cycle.
- Simultaneous push and pop otherwise: count unchanged and pointers both advance.
- Pointers wrap modulo DEPTH.
- out_valid falls after an edge where out_ready is high and no new issue occurs.
- cmd_count increments on out_valid && out_ready.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams OP_ADD through OP_XNOR (4'd0–4'd9).
  - OP_W = 4 and DATA_W = 8.
  - Command struct {op, a, b}.
- One sub-module is natural: alu_cmd_fifo, a synchronous FIFO with parameter DEPTH, width 20, ports push/pop/full/empty/count and the head data visible combinationally.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with 3 commands queued -> all outputs at reset values at once; after release, no stale output appears.
- Single ADD A = 8'hF0, B = 8'h20, ALU model attached -> out_valid one edge after accept; out_result 8'h10, out_carry 1, out_zero 0, out_err 0.
- Back-to-back SUB 5-5, MUL 16*17, XOR AA^55, out_ready high -> one result per cycle: 8'h00 with zero = 1; 8'h10; 8'hFF.
- DIV A = 8'h09, B = 0, then op 4'hC -> first gives result 8'hFF with err = 1; second gives 8'h00 with err = 1 and zero = 1.
- Backpressure: out_ready = 0, push DEPTH + 1 commands -> in_ready low after DEPTH + 1 accepts (DEPTH in FIFO + 1 in output), output held stable. Then release -> results drain in order, none lost or duplicated.
- Counter: force cmd_count to 16'hFFFF via 65535 handshakes or a backdoor, then complete one more -> cmd_count reads 0.
